// File: rtl/clk_pkg.sv
// Shared types and helpers for the divided-clock meter: FSM state encoding,
// default sizing constants and a saturating adder.
package clk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } meter_state_t;

    localparam int          DEF_CNT_W   = 32;
    localparam logic [31:0] DEF_TIMEOUT = 32'd1_000_000;

    // Adds two values that fit in w bits and clamps the result to 2**w-1.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (65'd1 << w) - 65'd1;
        return (sum > max_val) ? max_val[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous level followed by an edge detector;
// also suitable for buttons and UART lines.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   sync_out;

    assign sync_out = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            prev_reg <= sync_out;
        end
    end

    assign rise     = sync_out & ~prev_reg;
    assign fall     = ~sync_out & prev_reg;
    assign any_edge = sync_out ^ prev_reg;

endmodule

// File: rtl/clk_div_meter.sv
// Recovers the half-period / period of a slow square wave sampled in clk, with lock
// and loss-of-signal detection. Define CLK_DIV_METER_DUTY_EN to add duty-cycle outputs.
module clk_div_meter
    import clk_pkg::*;
#(
    parameter int               CNT_W       = DEF_CNT_W,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(DEF_TIMEOUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] half_period,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
`ifdef CLK_DIV_METER_DUTY_EN
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             duty_err,
`endif
    output logic             locked,
    output logic             timeout
);

    meter_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, prev_half_reg, half_reg, period_reg;
    logic [CNT_W-1:0] cnt_plus;
    logic             meas_valid_reg, timeout_reg;
    logic             rise, fall, sig_edge;
    logic             measuring, do_update, hit_timeout, match, duty_ok;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (sig_in),
        .rise     (rise),
        .fall     (fall),
        .any_edge (sig_edge)
    );

    assign cnt_plus  = cnt_reg + CNT_W'(1);
    assign measuring = (state_reg == MEASURE) || (state_reg == LOCKED);
    // An edge that coincides with meas_en falling is dropped.
    assign do_update = meas_en && sig_edge && measuring;
    // Fires on the cycle the counter steps onto TIMEOUT, so it triggers once per loss.
    assign hit_timeout = meas_en && !sig_edge && (state_reg != IDLE) &&
                         (cnt_reg == TIMEOUT - CNT_W'(1));
    assign match = (cnt_plus == prev_half_reg) && duty_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!meas_en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = ARMED;
                ARMED:   if (sig_edge) state_next = MEASURE;
                MEASURE: begin
                    if (hit_timeout)            state_next = ARMED;
                    else if (sig_edge && match) state_next = LOCKED;
                end
                LOCKED: begin
                    if (hit_timeout)             state_next = ARMED;
                    else if (sig_edge && !match) state_next = MEASURE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = (state_reg == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            prev_half_reg  <= '0;
            half_reg       <= '0;
            period_reg     <= '0;
            meas_valid_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            meas_valid_reg <= do_update;

            if (state_reg == IDLE || !meas_en) begin
                cnt_reg <= '0;
            end else if (sig_edge) begin
                cnt_reg <= '0;
            end else if (cnt_reg < TIMEOUT) begin
                cnt_reg <= cnt_plus;
            end

            // A fresh arm starts with no history, so the first period is half+0.
            if (!measuring || hit_timeout) begin
                prev_half_reg <= '0;
            end else if (do_update) begin
                prev_half_reg <= cnt_plus;
            end

            if (do_update) begin
                half_reg   <= cnt_plus;
                period_reg <= CNT_W'(sat_add(64'(cnt_plus), 64'(prev_half_reg), CNT_W));
            end

            if (hit_timeout) begin
                timeout_reg <= 1'b1;
            end else if (meas_en && sig_edge) begin
                timeout_reg <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_METER_DUTY_EN
    logic [CNT_W-1:0] high_reg, low_reg, duty_diff;
    logic             seen_high_reg, seen_low_reg, duty_err_int;

    // The interval ending on a falling edge was high time, on a rising edge low time.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_reg      <= '0;
            low_reg       <= '0;
            seen_high_reg <= 1'b0;
            seen_low_reg  <= 1'b0;
        end else if (do_update) begin
            if (fall) begin
                high_reg      <= cnt_plus;
                seen_high_reg <= 1'b1;
            end
            if (rise) begin
                low_reg      <= cnt_plus;
                seen_low_reg <= 1'b1;
            end
        end
    end

    assign duty_diff    = (high_reg > low_reg) ? (high_reg - low_reg) : (low_reg - high_reg);
    assign duty_err_int = seen_high_reg && seen_low_reg && (duty_diff > CNT_W'(1));
    assign duty_ok      = !duty_err_int;
    assign high_cnt     = high_reg;
    assign low_cnt      = low_reg;
    assign duty_err     = duty_err_int;
`else
    logic duty_unused;
    assign duty_unused = rise ^ fall;
    assign duty_ok     = 1'b1;
`endif

    assign half_period = half_reg;
    assign period      = period_reg;
    assign meas_valid  = meas_valid_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_clk_div_meter.sv
// Scoreboard bench for clk_div_meter: each toggle that should yield a measurement
// pushes its expected result; a monitor pops and compares on every meas_valid.
module tb_clk_div_meter;

    localparam int          CNT_W       = 32;
    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] TIMEOUT     = 32'd100;

    logic             clk = 1'b0;
    logic             reset;
    logic             sig_in;
    logic             meas_en;
    logic [CNT_W-1:0] half_period, period;
    logic             meas_valid, locked, timeout;
`ifdef CLK_DIV_METER_DUTY_EN
    logic [CNT_W-1:0] high_cnt, low_cnt;
    logic             duty_err;
`endif

    clk_div_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .meas_en     (meas_en),
        .half_period (half_period),
        .period      (period),
        .meas_valid  (meas_valid),
`ifdef CLK_DIV_METER_DUTY_EN
        .high_cnt    (high_cnt),
        .low_cnt     (low_cnt),
        .duty_err    (duty_err),
`endif
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] half;
        logic [31:0] per;
        logic        lk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_bad    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_meas(input int h, input int p, input logic l);
        exp_t e;
        e.half = 32'(h);
        e.per  = 32'(p);
        e.lk   = l;
        sb_q.push_back(e);
    endtask

    // Wait n clock cycles after the previous toggle, then toggle sig_in.
    task automatic tog(input int n);
        repeat (n) @(posedge clk);
        #1;
        sig_in = ~sig_in;
    endtask

    always @(negedge clk) begin
        if (!reset && meas_valid) begin
            check_val("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn half=%0d period=%0d locked=%0b (exp %0d/%0d/%0b)",
                         half_period, period, locked, e.half, e.per, e.lk);
                check_val("half_period", 64'(half_period), 64'(e.half));
                check_val("period", 64'(period), 64'(e.per));
                check_val("locked_at_valid", 64'(locked), 64'(e.lk));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        logic found;

        reset   = 1'b1;
        sig_in  = 1'b0;
        meas_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_half", 64'(half_period), 64'd0);
        check_val("rst_period", 64'(period), 64'd0);
        check_val("rst_valid", 64'(meas_valid), 64'd0);
        check_val("rst_locked", 64'(locked), 64'd0);
        check_val("rst_timeout", 64'(timeout), 64'd0);
        reset   = 1'b0;
        meas_en = 1'b1;

        // DIV=8: arm, then lock on the third edge.
        tog(3);
        tog(8); expect_meas(8, 8, 1'b0);
        tog(8); expect_meas(8, 16, 1'b1);
        tog(8); expect_meas(8, 16, 1'b1);
        // DIV switches to 5: drop lock, re-lock on second edge of 5.
        tog(5); expect_meas(5, 13, 1'b0);
        tog(5); expect_meas(5, 10, 1'b1);
        tog(5); expect_meas(5, 10, 1'b1);

        // Signal loss: timeout rises TIMEOUT cycles after the last edge.
        found = 1'b0;
        for (k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (timeout) begin
                found = 1'b1;
                break;
            end
        end
        check_val("timeout_seen", 64'(found), 64'd1);
        check_val("timeout_latency", 64'(k), 64'(SYNC_STAGES + 1 + int'(TIMEOUT)));
        check_val("timeout_locked", 64'(locked), 64'd0);

        tog(5);
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        check_val("timeout_cleared", 64'(timeout), 64'd0);
        tog(6 - (SYNC_STAGES + 1)); expect_meas(6, 6, 1'b0);
        tog(6); expect_meas(6, 12, 1'b1);

        // DIV=4 lock, then reset while locked.
        tog(4); expect_meas(4, 10, 1'b0);
        tog(4); expect_meas(4, 8, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_val("pre_reset_locked", 64'(locked), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_half", 64'(half_period), 64'd0);
        check_val("reset_period", 64'(period), 64'd0);
        check_val("reset_locked", 64'(locked), 64'd0);
        check_val("reset_timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        tog(2);
        tog(4); expect_meas(4, 4, 1'b0);
        tog(4); expect_meas(4, 8, 1'b1);

        // meas_en dropped while locked: lock clears, results hold, no updates.
        repeat (6) @(posedge clk);
        #1;
        meas_en = 1'b0;
        @(posedge clk);
        #1;
        check_val("en_low_locked", 64'(locked), 64'd0);
        check_val("en_low_half_hold", 64'(half_period), 64'd4);
        check_val("en_low_period_hold", 64'(period), 64'd8);
        tog(4);
        tog(4);
        tog(4);
        repeat (8) @(posedge clk);

`ifdef CLK_DIV_METER_DUTY_EN
        // 3-high / 7-low waveform never locks and flags duty error.
        #1;
        meas_en = 1'b1;
        tog(3);
        tog(3); expect_meas(3, 3, 1'b0);
        tog(7); expect_meas(7, 10, 1'b0);
        tog(3); expect_meas(3, 10, 1'b0);
        tog(7); expect_meas(7, 10, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check_val("duty_high", 64'(high_cnt), 64'd3);
        check_val("duty_low", 64'(low_cnt), 64'd7);
        check_val("duty_err", 64'(duty_err), 64'd1);
        check_val("duty_locked", 64'(locked), 64'd0);
`endif

        repeat (4) @(posedge clk);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
